// File: rtl/leaf_out_sched_if.sv
// -----------------------------------------------------------------------------
// leaf_out_sched_if
// Groups the user-side output streams and the BFT-side packet link that
// leaf_out_sched sits between.
//
//   din_leaf_user2interface  user payloads, port i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_user2interface       per-port payload valid (ap_vld)
//   ack_interface2user       per-port acknowledge (ap_ack), one-hot or zero
//   dout_leaf_interface2bft  packet to the BFT, MSB is the packet valid bit
//   bft_ready                BFT accepts the presented packet this cycle
//
// Modports:
//   master  environment side (user kernel + BFT)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface leaf_out_sched_if #(
  parameter int NUM_OUT_PORTS = 3,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
  logic                                  bft_ready;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    output bft_ready,
    input  ack_interface2user,
    input  dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  bft_ready,
    output ack_interface2user,
    output dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_out_sched.sv
// -----------------------------------------------------------------------------
// leaf_out_sched
// Round-robin scheduler sharing the single leaf->BFT packet link between
// NUM_OUT_PORTS user output streams. Each accepted payload word is wrapped in
// a packet {valid, dst_leaf, dst_port, src_leaf, src_port, payload} and held
// in the output register until the BFT accepts it. Per-port credit counters
// stop a port from overrunning its destination.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   self_leaf     this leaf's address, used as the packet src leaf
//   enable        permits new grants (a held packet still drains)
//   bus           leaf_out_sched_if.slave: user streams and BFT packet link
//   cfg_we/cfg_port/cfg_dst_leaf/cfg_dst_port   route-table write
//   credit_vld/credit_port/credit_amt           credit return
//   resend        retransmit request (used only with the optional feature)
//   busy          high while the output register holds a packet
//
// Optional feature: define LEAF_OUT_SCHED_RESEND_EN to keep the last
// BFT-accepted packet in a shadow register and replay it on resend.
// -----------------------------------------------------------------------------
module leaf_out_sched #(
  parameter int NUM_OUT_PORTS         = 3,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int PACKET_BITS           = 1 + 2*NUM_LEAF_BITS + 2*NUM_PORT_BITS + PAYLOAD_BITS,
  parameter int CREDIT_BITS           = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] self_leaf,
  input  logic                     enable,
  leaf_out_sched_if.slave          bus,
  input  logic                     cfg_we,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
  input  logic                     credit_vld,
  input  logic [NUM_PORT_BITS-1:0] credit_port,
  input  logic [CREDIT_BITS-1:0]   credit_amt,
  input  logic                     resend,
  output logic                     busy
);

  localparam int                     PTR_W       = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [PTR_W-1:0]       LAST_PORT   = PTR_W'(NUM_OUT_PORTS - 1);
  localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(FREESPACE_UPDATE_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [NUM_OUT_PORTS-1:0] route_vld;
  logic [NUM_LEAF_BITS-1:0] route_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] route_port [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit     [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_ptr;

  logic [NUM_OUT_PORTS-1:0]   elig;
  logic [NUM_OUT_PORTS-1:0]   elig_rot;
  logic                       found;
  logic [PTR_W-1:0]           offs;
  logic [PTR_W:0]             wsum;
  logic [PTR_W-1:0]           winner;
  logic                       slot_free;
  logic                       grant;
  logic                       resend_go;
  logic [NUM_OUT_PORTS-1:0]   ack;
  logic [PAYLOAD_BITS-1:0]    win_payload;
  logic [NUM_LEAF_BITS-1:0]   win_leaf;
  logic [NUM_PORT_BITS-1:0]   win_port;
  logic [PACKET_BITS-1:0]     new_pkt;
  logic                       load_new;
  logic                       load_shadow;
  logic                       drop;
  logic [PACKET_BITS-1:0]     pkt_p1;
  logic [PACKET_BITS-1:0]     shadow_pkt;

  // Credit update with saturation at the counter maximum. A grant is only
  // issued on a non-zero credit, so the decrement never underflows.
  function automatic logic [CREDIT_BITS-1:0] credit_next(
    input logic [CREDIT_BITS-1:0] cur,
    input logic                   ret,
    input logic [CREDIT_BITS-1:0] amt,
    input logic                   take
  );
    logic [CREDIT_BITS:0] sum;
    sum = {1'b0, cur};
    if (ret)  sum = sum + {1'b0, amt};
    if (take) sum = sum - 1'b1;
    if (sum[CREDIT_BITS]) return {CREDIT_BITS{1'b1}};
    return sum[CREDIT_BITS-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i] = bus.vld_user2interface[i] & (credit[i] != '0) & route_vld[i] & enable;
    end
  end

  // Rotate eligibility so the RR pointer lands on bit 0, take the first set
  // bit, then rotate the offset back into a port index.
  always_comb begin
    elig_rot = NUM_OUT_PORTS'({elig, elig} >> rr_ptr);
    found    = 1'b0;
    offs     = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      if (!found && elig_rot[k]) begin
        found = 1'b1;
        offs  = PTR_W'(k);
      end
    end
    wsum = {1'b0, rr_ptr} + {1'b0, offs};
    if (wsum >= (PTR_W+1)'(NUM_OUT_PORTS)) wsum = wsum - (PTR_W+1)'(NUM_OUT_PORTS);
    winner = wsum[PTR_W-1:0];
  end

  assign slot_free = (state == IDLE) || ((state == HOLD) && bus.bft_ready);
  assign grant     = found && slot_free && !resend_go;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      ack[i] = grant && (winner == PTR_W'(i));
    end
  end

  assign bus.ack_interface2user = ack;

  always_comb begin
    win_payload = '0;
    win_leaf    = '0;
    win_port    = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (winner == PTR_W'(i)) begin
        win_payload = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        win_leaf    = route_leaf[i];
        win_port    = route_port[i];
      end
    end
  end

  assign new_pkt = {1'b1, win_leaf, win_port, self_leaf, NUM_PORT_BITS'(winner), win_payload};

  always_comb begin
    state_nx    = state;
    load_new    = 1'b0;
    load_shadow = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        if (resend_go) begin
          state_nx    = HOLD;
          load_shadow = 1'b1;
        end else if (grant) begin
          state_nx = HOLD;
          load_new = 1'b1;
        end
      end
      HOLD: begin
        if (bus.bft_ready) begin
          if (grant) begin
            load_new = 1'b1;
          end else begin
            state_nx = IDLE;
            drop     = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy = (state == HOLD);

  // ---- stage p1: output packet register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_p1 <= '0;
    end else if (load_new) begin
      pkt_p1 <= new_pkt;
    end else if (load_shadow) begin
      pkt_p1 <= shadow_pkt;
    end else if (drop) begin
      pkt_p1[PACKET_BITS-1] <= 1'b0;
    end
  end

  assign bus.dout_leaf_interface2bft = pkt_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (winner == LAST_PORT) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) credit[i] <= CREDIT_INIT;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_next(credit[i],
                                 credit_vld && (credit_port == NUM_PORT_BITS'(i)),
                                 credit_amt, ack[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_we && (cfg_port == NUM_PORT_BITS'(i))) route_vld[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (cfg_we && (cfg_port == NUM_PORT_BITS'(i))) begin
        route_leaf[i] <= cfg_dst_leaf;
        route_port[i] <= cfg_dst_port;
      end
    end
  end

`ifdef LEAF_OUT_SCHED_RESEND_EN
  logic shadow_vld;
  logic resend_pend;

  // A resend is served only from IDLE; one arriving during HOLD waits in
  // resend_pend. IDLE always clears the pending flag, so a request against
  // an empty shadow is simply dropped.
  assign resend_go = (state == IDLE) && (resend || resend_pend) && shadow_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_vld  <= 1'b0;
      resend_pend <= 1'b0;
    end else begin
      if ((state == HOLD) && bus.bft_ready) shadow_vld <= 1'b1;
      if (state == IDLE)  resend_pend <= 1'b0;
      else if (resend)    resend_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == HOLD) && bus.bft_ready) shadow_pkt <= pkt_p1;
  end
`else
  logic unused_resend;

  assign resend_go     = 1'b0;
  assign shadow_pkt    = '0;
  assign unused_resend = resend;
`endif

endmodule

// File: tb/tb_leaf_out_sched.sv
module tb_leaf_out_sched;

  logic       clk;
  logic       reset;
  logic [3:0] self_leaf;
  logic       enable;
  logic       cfg_we;
  logic [3:0] cfg_port;
  logic [3:0] cfg_dst_leaf;
  logic [3:0] cfg_dst_port;
  logic       credit_vld;
  logic [3:0] credit_port;
  logic [6:0] credit_amt;
  logic       resend;
  logic       busy;

  int total;
  int bad;

  leaf_out_sched_if #(.NUM_OUT_PORTS(3), .PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

  leaf_out_sched dut (
    .clk          (clk),
    .reset        (reset),
    .self_leaf    (self_leaf),
    .enable       (enable),
    .bus          (bus),
    .cfg_we       (cfg_we),
    .cfg_port     (cfg_port),
    .cfg_dst_leaf (cfg_dst_leaf),
    .cfg_dst_port (cfg_dst_port),
    .credit_vld   (credit_vld),
    .credit_port  (credit_port),
    .credit_amt   (credit_amt),
    .resend       (resend),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] vld;
    logic       rdy;
    logic       en;
    logic [2:0] ack;
    logic       dv;
    int         src;
    logic       bsy;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] payload_of(input int p);
    case (p)
      0:       return 32'hDEADBEEF;
      1:       return 32'h11111111;
      default: return 32'h22222222;
    endcase
  endfunction

  // Routes: port0 -> (2,1), port1 -> (3,2), port2 -> (4,3); self_leaf = 5.
  function automatic logic [48:0] pkt_exp(input int p, input logic [31:0] pl);
    logic [3:0] lf;
    logic [3:0] pt;
    case (p)
      0:       begin lf = 4'h2; pt = 4'h1; end
      1:       begin lf = 4'h3; pt = 4'h2; end
      default: begin lf = 4'h4; pt = 4'h3; end
    endcase
    return {1'b1, lf, pt, 4'h5, 4'(p), pl};
  endfunction

  task automatic config_routes();
    for (int p = 0; p < 3; p++) begin
      cfg_we       = 1'b1;
      cfg_port     = 4'(p);
      cfg_dst_leaf = 4'(p + 2);
      cfg_dst_port = 4'(p + 1);
      cyc();
    end
    // Out-of-range index whose low bits alias port 0: must not land anywhere.
    cfg_port     = 4'd4;
    cfg_dst_leaf = 4'hF;
    cfg_dst_port = 4'hF;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic count_acks(input int p, input int ncyc, output int cnt);
    logic [2:0] a;
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      a = bus.ack_interface2user;
      if (a[p[1:0]]) cnt++;
      cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    int cnt;
    total = 0;
    bad   = 0;

    reset        = 1'b0;
    self_leaf    = 4'h5;
    enable       = 1'b1;
    cfg_we       = 1'b0;
    cfg_port     = '0;
    cfg_dst_leaf = '0;
    cfg_dst_port = '0;
    credit_vld   = 1'b0;
    credit_port  = '0;
    credit_amt   = '0;
    resend       = 1'b0;
    bus.vld_user2interface      = 3'b000;
    bus.bft_ready               = 1'b1;
    bus.din_leaf_user2interface = {32'h22222222, 32'h11111111, 32'hDEADBEEF};

    tbl[0]  = '{3'b001, 1'b1, 1'b1, 3'b001, 1'b0, 0, 1'b0};
    tbl[1]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 0, 1'b1};
    tbl[2]  = '{3'b111, 1'b1, 1'b1, 3'b010, 1'b0, 0, 1'b0};
    tbl[3]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 1, 1'b1};
    tbl[4]  = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2, 1'b1};
    tbl[5]  = '{3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 0, 1'b1};
    tbl[6]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 1, 1'b1};
    tbl[7]  = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 2, 1'b1};
    tbl[8]  = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 2, 1'b1};
    tbl[9]  = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 2, 1'b1};
    tbl[10] = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 2, 1'b1};
    tbl[11] = '{3'b111, 1'b0, 1'b1, 3'b000, 1'b1, 2, 1'b1};
    tbl[12] = '{3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 2, 1'b1};
    tbl[13] = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 0, 1'b1};
    tbl[14] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 0, 1'b1};
    tbl[15] = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 0, 1'b0};
    tbl[16] = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 0, 1'b0};
    tbl[17] = '{3'b100, 1'b1, 1'b1, 3'b100, 1'b0, 0, 1'b0};
    tbl[18] = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 2, 1'b1};
    tbl[19] = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 0, 1'b0};

    // Reset state
    cyc();
    @(negedge clk);
    check("rst_ack",  64'(bus.ack_interface2user), 64'd0);
    check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // Routes are invalid out of reset: nothing may be granted
    bus.vld_user2interface = 3'b111;
    @(negedge clk);
    check("no_route_ack", 64'(bus.ack_interface2user), 64'd0);
    cyc();
    bus.vld_user2interface = 3'b000;
    config_routes();

    // Table: single packet, round robin back-to-back, stall, enable gating
    for (int r = 0; r < 20; r++) begin
      bus.vld_user2interface = tbl[r].vld;
      bus.bft_ready          = tbl[r].rdy;
      enable                 = tbl[r].en;
      @(negedge clk);
      check($sformatf("row%0d_ack", r), 64'(bus.ack_interface2user), 64'(tbl[r].ack));
      check($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].bsy));
      if (tbl[r].dv)
        check($sformatf("row%0d_dout", r), 64'(bus.dout_leaf_interface2bft),
              64'(pkt_exp(tbl[r].src, payload_of(tbl[r].src))));
      else
        check($sformatf("row%0d_dv", r), 64'(bus.dout_leaf_interface2bft[48]), 64'd0);
      cyc();
    end
    enable        = 1'b1;
    bus.bft_ready = 1'b1;

    // Reset asserted while holding a packet
    bus.vld_user2interface = 3'b001;
    bus.bft_ready          = 1'b0;
    @(negedge clk);
    check("pre_hold_ack", 64'(bus.ack_interface2user), 64'b001);
    cyc();
    check("hold_dout", 64'(bus.dout_leaf_interface2bft), 64'(pkt_exp(0, 32'hDEADBEEF)));
    #2;
    reset = 1'b0;
    #1;
    check("midrst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    check("midrst_ack",  64'(bus.ack_interface2user), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    cyc();
    reset = 1'b1;
    bus.vld_user2interface = 3'b000;
    bus.bft_ready          = 1'b1;
    cyc();
    config_routes();

    // Every port holds exactly 64 credits after reset
    for (int q = 0; q < 3; q++) begin
      int p;
      p = (q == 0) ? 0 : ((q == 1) ? 2 : 1);
      bus.vld_user2interface = 3'(1 << p);
      count_acks(p, 70, cnt);
      check($sformatf("credit64_p%0d", p), 64'(cnt), 64'd64);
      bus.vld_user2interface = 3'b000;
      cyc();
      cyc();
    end

    // Port 1 is out of credit; an out-of-range return aliasing port 1 is ignored
    bus.vld_user2interface = 3'b010;
    credit_vld  = 1'b1;
    credit_port = 4'd5;
    credit_amt  = 7'd3;
    @(negedge clk);
    check("p1_empty_ack", 64'(bus.ack_interface2user), 64'd0);
    cyc();
    credit_vld = 1'b0;
    @(negedge clk);
    check("oor_credit_ack", 64'(bus.ack_interface2user), 64'd0);
    cyc();

    // Return 3 credits to port 1 -> exactly 3 more words
    credit_vld  = 1'b1;
    credit_port = 4'd1;
    credit_amt  = 7'd3;
    @(negedge clk);
    check("ret3_same_cycle_ack", 64'(bus.ack_interface2user), 64'd0);
    cyc();
    credit_vld = 1'b0;
    count_acks(1, 10, cnt);
    check("ret3_words", 64'(cnt), 64'd3);
    bus.vld_user2interface = 3'b000;
    cyc();
    cyc();

    // Give 2 credits, then grant and return 1 in the same cycle -> still 2
    credit_vld  = 1'b1;
    credit_port = 4'd1;
    credit_amt  = 7'd2;
    cyc();
    bus.vld_user2interface = 3'b010;
    credit_amt = 7'd1;
    @(negedge clk);
    check("grant_ret_ack", 64'(bus.ack_interface2user), 64'b010);
    cyc();
    credit_vld = 1'b0;
    count_acks(1, 10, cnt);
    check("grant_ret_words", 64'(cnt), 64'd2);
    bus.vld_user2interface = 3'b000;
    cyc();
    cyc();

    // Saturation: two returns of 127 to an empty port 0 cap at 127
    credit_vld  = 1'b1;
    credit_port = 4'd0;
    credit_amt  = 7'd127;
    cyc();
    cyc();
    credit_vld = 1'b0;
    bus.vld_user2interface = 3'b001;
    count_acks(0, 135, cnt);
    check("sat_words", 64'(cnt), 64'd127);
    bus.vld_user2interface = 3'b000;
    cyc();
    cyc();

    // Resend path
    do_reset();
    config_routes();
    bus.din_leaf_user2interface = {32'h22222222, 32'h11111111, 32'h11223344};
    bus.vld_user2interface = 3'b001;
    @(negedge clk);
    check("rs_first_ack", 64'(bus.ack_interface2user), 64'b001);
    cyc();
    bus.vld_user2interface = 3'b000;
    @(negedge clk);
    check("rs_first_pkt", 64'(bus.dout_leaf_interface2bft), 64'(pkt_exp(0, 32'h11223344)));
    cyc();
    @(negedge clk);
    check("rs_idle_dv", 64'(bus.dout_leaf_interface2bft[48]), 64'd0);
    cyc();
`ifdef LEAF_OUT_SCHED_RESEND_EN
    resend = 1'b1;
    bus.vld_user2interface = 3'b001;
    @(negedge clk);
    check("rs_priority_ack", 64'(bus.ack_interface2user), 64'd0);
    cyc();
    resend = 1'b0;
    bus.vld_user2interface = 3'b000;
    @(negedge clk);
    check("rs_replay_pkt", 64'(bus.dout_leaf_interface2bft), 64'(pkt_exp(0, 32'h11223344)));
    check("rs_replay_busy", 64'(busy), 64'd1);
    cyc();
`else
    resend = 1'b1;
    @(negedge clk);
    cyc();
    resend = 1'b0;
    @(negedge clk);
    check("rs_ignored_dv", 64'(bus.dout_leaf_interface2bft[48]), 64'd0);
    check("rs_ignored_busy", 64'(busy), 64'd0);
    cyc();
`endif
    bus.vld_user2interface = 3'b001;
    count_acks(0, 70, cnt);
    check("rs_credit_left", 64'(cnt), 64'd63);
    bus.vld_user2interface = 3'b000;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
